// File: rtl/lcb_poll_sched.sv
// lcb_poll_sched: round-robin time-slot poller for the local channel blocks.
// Each slot issues a request strobe to one channel, waits for its response
// word on the shared bus (with timeout) and writes it into the write half of
// the ping-pong frame memory.
// Optional build macro TIMEOUT_FILL_EN: a timed-out channel still gets a
// fill word (all ones) written so frame word positions stay fixed.
//
// state | meaning
// IDLE  | waiting for slot count 0 to decide whether to poll this channel
// REQ   | request strobe high for RQ_W clocks, early response accepted
// WAIT  | strobe low, waiting for the response word or the timeout
// WRITE | one-clock memory write of the captured response, index advances
// FILL  | one-clock memory write of the fill word after a timeout
// DONE  | slot finished, bus ignored until the slot wraps
module lcb_poll_sched #(
    parameter int NCH  = 4,
    parameter int SLOT = 768,
    parameter int RQ_W = 20,
    parameter int TMO  = 500,
    parameter int DW   = 12,
    parameter int AW   = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  iChEn,
    input  logic            iSwitch,
    input  logic            iValid,
    input  logic [DW-1:0]   iData,
    input  logic            iErrClr,
    output logic [NCH-1:0]  oRq,
    output logic            oWrEn,
    output logic [AW-1:0]   oWrAddr,
    output logic [DW-1:0]   oWrData,
    output logic [4:0]      oLCB_num,
    output logic [NCH-1:0]  oErr,
    output logic            oStray
);

    localparam int SCW = $clog2(SLOT);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW  = $clog2(TMO + 1);
    localparam int IW  = AW - 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FILL, DONE} state_t;

    state_t          state;
    logic [SCW-1:0]  slotCnt;
    logic [CHW-1:0]  ch;
    logic [TW-1:0]   tmr;
    logic [IW-1:0]   idx;
    logic            bank;
    logic            slotEnd;
    logic            timeout;
    logic [NCH-1:0]  chMask;
    logic [NCH-1:0]  errSet;
    logic            straySet;

    // Slot boundary, timer terminal count and sticky-flag set events
    always_comb begin
        slotEnd  = (slotCnt == SCW'(SLOT - 1));
        timeout  = (tmr == '0);
        chMask   = NCH'(1) << ch;
        errSet   = '0;
        straySet = 1'b0;
        if ((state == REQ || state == WAIT) && slotEnd)
            errSet = chMask;
        else if (state == WAIT && timeout && !iValid)
            errSet = chMask;
        if (iValid && state != REQ && state != WAIT)
            straySet = 1'b1;
    end

    // Slot counter, channel pointer and poll round counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slotCnt  <= '0;
            ch       <= '0;
            oLCB_num <= '0;
        end else if (slotEnd) begin
            slotCnt <= '0;
            if (ch == CHW'(NCH - 1)) begin
                ch       <= '0;
                oLCB_num <= oLCB_num + 5'd1;
            end else begin
                ch <= ch + CHW'(1);
            end
        end else begin
            slotCnt <= slotCnt + SCW'(1);
        end
    end

    // Sticky error flags; a set event in the same clock beats the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oErr   <= '0;
            oStray <= 1'b0;
        end else begin
            oErr   <= (iErrClr ? '0 : oErr) | errSet;
            oStray <= (iErrClr ? 1'b0 : oStray) | straySet;
        end
    end

    // Poll FSM with registered request and memory-write outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            oRq     <= '0;
            oWrEn   <= 1'b0;
            oWrAddr <= '0;
            oWrData <= '0;
            tmr     <= '0;
            idx     <= '0;
            bank    <= 1'b0;
        end else begin
            oWrEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (slotCnt == '0 && iChEn[ch]) begin
                        state <= REQ;
                        oRq   <= chMask;
                        bank  <= ~iSwitch;
                        tmr   <= TW'(TMO - 1);
                    end
                end
                REQ: begin
                    tmr <= tmr - TW'(1);
                    if (slotEnd) begin
                        state <= IDLE;
                        oRq   <= '0;
                    end else if (iValid) begin
                        state   <= WRITE;
                        oRq     <= '0;
                        oWrEn   <= 1'b1;
                        oWrAddr <= {bank, idx};
                        oWrData <= iData;
                    end else if (tmr == TW'(TMO - RQ_W)) begin
                        state <= WAIT;
                        oRq   <= '0;
                    end
                end
                WAIT: begin
                    tmr <= tmr - TW'(1);
                    if (slotEnd) begin
                        state <= IDLE;
                    end else if (iValid) begin
                        state   <= WRITE;
                        oWrEn   <= 1'b1;
                        oWrAddr <= {bank, idx};
                        oWrData <= iData;
                    end else if (timeout) begin
`ifdef TIMEOUT_FILL_EN
                        state   <= FILL;
                        oWrEn   <= 1'b1;
                        oWrAddr <= {bank, idx};
                        oWrData <= '1;
`else
                        state <= DONE;
`endif
                    end
                end
                WRITE, FILL: begin
                    idx   <= idx + IW'(1);
                    state <= slotEnd ? IDLE : DONE;
                end
                DONE: begin
                    if (slotEnd)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
